// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, tail FSM states and GF(2^8) helpers
// used by the inverse-round tail (AddRoundKey followed by InvMixColumns).
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_DONE = 2'd2
  } inv_round_state_e;

  // Multiply by x (0x02) modulo the AES polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column; s0 is the top byte.
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] i_col,
  output logic [AES_COL_W-1:0] o_col
);

  logic [7:0] w_s0, w_s1, w_s2, w_s3;

  assign w_s0 = i_col[31:24];
  assign w_s1 = i_col[23:16];
  assign w_s2 = i_col[15:8];
  assign w_s3 = i_col[7:0];

  // Coefficient row {0e,0b,0d,09}, rotated right by one for each output byte
  always_comb begin
    o_col[31:24] = mul0e(w_s0) ^ mul0b(w_s1) ^ mul0d(w_s2) ^ mul09(w_s3);
    o_col[23:16] = mul09(w_s0) ^ mul0e(w_s1) ^ mul0b(w_s2) ^ mul0d(w_s3);
    o_col[15:8]  = mul0d(w_s0) ^ mul09(w_s1) ^ mul0e(w_s2) ^ mul0b(w_s3);
    o_col[7:0]   = mul0b(w_s0) ^ mul0d(w_s1) ^ mul09(w_s2) ^ mul0e(w_s3);
  end

endmodule

// File: rtl/aes_inv_round_tail.sv
// Inverse-round tail: latches state^key, then runs InvMixColumns one column
// per cycle in place through a single shared column unit (skipped on the
// final round). Result is held until the consumer takes it.
module aes_inv_round_tail
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_state,
  input  logic [AES_BLOCK_W-1:0] in_key,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_state,
  output logic                   busy
);

  inv_round_state_e       r_fsm;
  logic [AES_BLOCK_W-1:0] r_state;
  logic [1:0]             r_col;
  logic                   r_last;

  logic [AES_COL_W-1:0]   w_col_in;
  logic [AES_COL_W-1:0]   w_col_out;

  // Select the column currently being mixed
  always_comb begin
    w_col_in = r_state[127:96];
    case (r_col)
      2'd0: w_col_in = r_state[127:96];
      2'd1: w_col_in = r_state[95:64];
      2'd2: w_col_in = r_state[63:32];
      2'd3: w_col_in = r_state[31:0];
      default: w_col_in = r_state[127:96];
    endcase
  end

  inv_mix_column u_inv_mix_column (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  // Control FSM plus the in-place state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_col   <= 2'd0;
      r_last  <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= in_state ^ in_key;
            r_last  <= in_last;
            r_col   <= 2'd0;
            r_fsm   <= in_last ? ST_DONE : ST_MIX;
          end
        end
        ST_MIX: begin
          if (r_last) begin
            // A final-round block never needs mixing
            r_fsm <= ST_DONE;
          end else begin
            case (r_col)
              2'd0: r_state[127:96] <= w_col_out;
              2'd1: r_state[95:64]  <= w_col_out;
              2'd2: r_state[63:32]  <= w_col_out;
              2'd3: r_state[31:0]   <= w_col_out;
              default: r_state[127:96] <= w_col_out;
            endcase
            if (r_col == 2'd3) begin
              r_col <= 2'd0;
              r_fsm <= ST_DONE;
            end else begin
              r_col <= r_col + 2'd1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_fsm <= ST_IDLE;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  // Handshake and status flags decode straight from the state register
  assign in_ready  = (r_fsm == ST_IDLE);
  assign out_valid = (r_fsm == ST_DONE);
  assign busy      = (r_fsm != ST_IDLE);
  assign out_state = r_state;

endmodule

// File: tb/tb_aes_inv_round_tail.sv
// Self-checking bench for aes_inv_round_tail: directed vectors, backpressure,
// mid-block reset and randomized back-to-back traffic against a GF(2^8) model.
module tb_aes_inv_round_tail;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  aes_inv_round_tail dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference GF(2^8) multiply: shift-and-add with reduction by 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int aa, bb, p;
    aa = a; bb = b; p = 0;
    for (int k = 0; k < 8; k++) begin
      if (bb % 2 == 1) p = p ^ aa;
      bb = bb / 2;
      aa = aa * 2;
      if (aa > 255) aa = aa ^ 'h11B;
    end
    return p[7:0];
  endfunction

  // Reference tail: matrix product of the inverse MixColumns matrix per column
  function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                         input logic last);
    logic [127:0] x, y;
    logic [7:0] coef [4];
    logic [7:0] acc;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    x = st ^ key;
    if (last) return x;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - r + 4) % 4], x[127 - 8*(4*c + k) -: 8]);
        y[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return y;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Send one block, hold it in DONE for 'hold' cycles, then accept it
  task automatic run_block(input logic [127:0] st, input logic [127:0] key, input logic last,
                           input int hold, input string tag,
                           output logic [127:0] res, output int lat);
    logic [127:0] first;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_in_ready_idle: got %b want 1", tag, in_ready);
    end
    in_state = st; in_key = key; in_last = last; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = rand128(); in_key = rand128();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    first = out_state;
    res = first;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_state !== first || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s_hold%0d: valid=%b ready=%b busy=%b state=%h want 1/0/1 %h",
                 tag, i, out_valid, in_ready, busy, out_state, first);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_release: valid=%b ready=%b busy=%b want 0/1/0",
               tag, out_valid, in_ready, busy);
    end
    $display("%s: in=%h key=%h last=%b -> out=%h lat=%0d", tag, st, key, last, res, lat);
  endtask

  task automatic check_block(input string tag, input logic [127:0] got, input logic [127:0] want,
                             input int lat, input int want_lat);
    n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL %s_data: got %h want %h", tag, got, want);
    end
    n_cmp++;
    if (lat !== want_lat) begin
      n_err++; $display("FAIL %s_latency: got %0d want %0d", tag, lat, want_lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    in_state = '0; in_key = '0;
    #12;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_state !== 128'h0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b valid=%b busy=%b state=%h want 1/0/0/0",
               in_ready, out_valid, busy, out_state);
    end
    // Offer a block while reset is held: it must not be taken
    in_valid = 1'b1; in_state = 128'h1234; in_key = 128'h0; in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_state !== 128'h0) begin
      n_err++;
      $display("FAIL reset_no_accept: ready=%b busy=%b valid=%b state=%h want 1/0/0/0",
               in_ready, busy, out_valid, out_state);
    end
    $display("reset: ready=%b valid=%b busy=%b state=%h", in_ready, out_valid, busy, out_state);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [127:0] res;
    int lat;
    run_block(128'h8e4da1bc_8e4da1bc_01010101_c6c6c6c6, 128'h0, 1'b0, 0, "vec_mix", res, lat);
    check_block("vec_mix", res, 128'hdb135345_db135345_01010101_c6c6c6c6, lat, 5);
    run_block(128'h71b25e43_71b25e43_fefefefe_39393939, {4{32'hffffffff}}, 1'b0, 0,
              "vec_key", res, lat);
    check_block("vec_key", res, 128'hdb135345_db135345_01010101_c6c6c6c6, lat, 5);
    run_block(128'h0, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1, 0, "vec_last", res, lat);
    check_block("vec_last", res, 128'h00010203_04050607_08090a0b_0c0d0e0f, lat, 1);
  endtask

  task automatic test_backpressure();
    logic [127:0] st, key, res;
    int lat;
    st = rand128(); key = rand128();
    run_block(st, key, 1'b0, 10, "backpressure", res, lat);
    check_block("backpressure", res, model(st, key, 1'b0), lat, 5);
  endtask

  task automatic test_reset_mid_mix();
    logic [127:0] res;
    int lat;
    @(negedge clk);
    in_state = rand128(); in_key = rand128(); in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 128'h0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midmix_reset: valid=%b ready=%b busy=%b state=%h want 0/1/0/0",
               out_valid, in_ready, busy, out_state);
    end
    $display("midmix_reset: valid=%b ready=%b state=%h", out_valid, in_ready, out_state);
    @(negedge clk);
    rst = 1'b0;
    run_block(128'h8e4da1bc_8e4da1bc_01010101_c6c6c6c6, 128'h0, 1'b0, 0, "post_reset", res, lat);
    check_block("post_reset", res, 128'hdb135345_db135345_01010101_c6c6c6c6, lat, 5);
  endtask

  // Continuous traffic with fresh random input every cycle: checks data,
  // order, that MIX ignores the input, and the accept-to-accept spacing.
  task automatic test_back_to_back(input logic last);
    logic [127:0] exp_q[$];
    int acc_q[$];
    int n_out;
    int waited;
    logic [127:0] want;
    n_out = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_unexpected_out: got %h want none", out_state);
        end else begin
          want = exp_q.pop_front();
          if (out_state !== want) begin
            n_err++; $display("FAIL b2b_data%0d: got %h want %h", n_out, out_state, want);
          end
          $display("b2b last=%b out%0d=%h", last, n_out, out_state);
          n_out++;
        end
      end
      in_state = rand128(); in_key = rand128(); in_last = last; in_valid = 1'b1;
      if (in_ready === 1'b1) begin
        exp_q.push_back(model(in_state, in_key, last));
        acc_q.push_back(cyc);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      if (out_valid === 1'b1) begin
        want = exp_q.pop_front();
        n_cmp++;
        if (out_state !== want) begin
          n_err++; $display("FAIL b2b_drain_data: got %h want %h", out_state, want);
        end
        $display("b2b last=%b out%0d=%h", last, n_out, out_state);
        n_out++;
      end
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL b2b_drain_timeout: left %0d want 0", exp_q.size());
    end
    for (int i = 1; i < acc_q.size(); i++) begin
      n_cmp++;
      if (acc_q[i] - acc_q[i-1] != (last ? 2 : 6)) begin
        n_err++;
        $display("FAIL b2b_spacing%0d: got %0d want %0d", i, acc_q[i] - acc_q[i-1],
                 last ? 2 : 6);
      end
    end
    n_cmp++;
    if (acc_q.size() < (last ? 15 : 5)) begin
      n_err++; $display("FAIL b2b_accept_count: got %0d want >= %0d", acc_q.size(), last ? 15 : 5);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_mix();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
